// File: rtl/reg_dbg_seq_if.sv
// Debug-host command/response bus for reg_dbg_seq.
//
// Handshake rules (both channels):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The source raises valid and holds it, together with its payload,
//   unchanged until that transfer edge. The sink may raise or lower ready at
//   any time, and ready never depends combinationally on valid.
//   Request channel: host drives req_valid_i/we/addr/wdata, sequencer drives req_ready_o.
//   Response channel: sequencer drives rsp_valid_o/rdata/err, host drives rsp_ready_i.
interface reg_dbg_seq_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [4:0]  req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;

  // Host side: issues commands, consumes responses.
  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  // Sequencer side.
  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/reg_dbg_seq.sv
// Debug register-file access sequencer.
// Takes one read or write command at a time from the debug host. It drives the
// register file's debug port while keeping clear of the core's writeback port.
// If the core holds the debug access off for too long, the sequencer asks the
// core to halt writeback until the response has been delivered.
module reg_dbg_seq #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  reg_dbg_seq_if.slave     host,
  input  logic             core_we_i,
  input  logic [4:0]       core_waddr_i,
  output logic             halt_req_o,
  output logic             rf_we_o,
  output logic [4:0]       rf_addr_o,
  output logic [31:0]      rf_wdata_o,
  input  logic [31:0]      rf_rdata_i,
  output logic [1:0]       dbg_state,
  output logic [7:0]       dbg_starve_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t      state_q;
  logic        we_q;
  logic [4:0]  addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  starve_q;
  logic        halt_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        addr_is_x0;
  logic        blocked;

  assign addr_is_x0 = (addr_q == 5'd0);

  // Collision check against the core's writeback port.
  // A debug write must not share the write cycle with any real core
  // writeback. A debug read only has to wait for a writeback to the same
  // register, so that it returns the new value. A write to x0 is discarded
  // and a read of x0 is the constant 0, so neither one ever waits.
  always_comb begin
    blocked = 1'b0;
    if (we_q) begin
      blocked = core_we_i && (core_waddr_i != 5'd0) && !addr_is_x0;
    end else begin
      blocked = core_we_i && (core_waddr_i == addr_q) && !addr_is_x0;
    end
  end

  // Sequencer FSM: accepts a command, issues it, then holds the response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= 5'd0;
      wdata_q  <= 32'd0;
      starve_q <= 8'd0;
      halt_q   <= 1'b0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (host.req_valid_i) begin
            we_q     <= host.req_we_i;
            addr_q   <= host.req_addr_i;
            wdata_q  <= host.req_wdata_i;
            starve_q <= 8'd0;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          if (blocked) begin
            if (starve_q != LIMIT) begin
              starve_q <= starve_q + 8'd1;
            end
          end else begin
            // Write responses carry no data; x0 reads are the constant 0.
            rdata_q <= (we_q || addr_is_x0) ? 32'd0 : rf_rdata_i;
            err_q   <= we_q && addr_is_x0;
            state_q <= RESP;
          end
          // Counter reached the limit: request a halt from the next cycle on.
          if (starve_q == LIMIT) begin
            halt_q <= 1'b1;
          end
        end
        RESP: begin
          if (host.rsp_ready_i) begin
            halt_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Debug-port write fires only in an unblocked ISSUE cycle, and is killed
  // directly by reset so an aborted command never reaches the register file.
  always_comb begin
    rf_we_o = 1'b0;
    if (rst && (state_q == ISSUE) && we_q && !addr_is_x0 && !blocked) begin
      rf_we_o = 1'b1;
    end
  end

  assign rf_addr_o        = addr_q;
  assign rf_wdata_o       = wdata_q;
  assign halt_req_o       = halt_q;

  assign host.req_ready_o = (state_q == IDLE);
  assign host.rsp_valid_o = (state_q == RESP);
  assign host.rsp_rdata_o = rdata_q;
  assign host.rsp_err_o   = err_q;

  assign dbg_state        = state_q;
  assign dbg_starve_cnt   = starve_q;

endmodule

// File: tb/tb_reg_dbg_seq.sv
// Directed testbench for reg_dbg_seq.
module tb_reg_dbg_seq;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;

  logic        clk;
  logic        rst;
  logic        core_we_i;
  logic [4:0]  core_waddr_i;
  logic        halt_req_o;
  logic        rf_we_o;
  logic [4:0]  rf_addr_o;
  logic [31:0] rf_wdata_o;
  logic [31:0] rf_rdata_i;
  logic [1:0]  dbg_state;
  logic [7:0]  dbg_starve_cnt;

  int n_checks;
  int n_errors;
  logic [31:0] exp_q[$];

  reg_dbg_seq_if bus ();

  reg_dbg_seq #(.STARVE_LIMIT(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .host           (bus),
    .core_we_i      (core_we_i),
    .core_waddr_i   (core_waddr_i),
    .halt_req_o     (halt_req_o),
    .rf_we_o        (rf_we_o),
    .rf_addr_o      (rf_addr_o),
    .rf_wdata_o     (rf_wdata_o),
    .rf_rdata_i     (rf_rdata_i),
    .dbg_state      (dbg_state),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command in the current (IDLE) cycle; returns in cycle 1 with valid dropped.
  task automatic send(input string tag, input logic we, input logic [4:0] addr,
                      input logic [31:0] wdata);
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = we;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    #1;
    check({tag, "_accept_ready"}, 32'(bus.req_ready_o), 32'd1);
    tick();
    bus.req_valid_i = 1'b0;
  endtask

  // Compare the presented response against the oldest expected entry.
  task automatic check_rsp(input string tag, input logic err);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'd1);
    check({tag, "_rsp_pending"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      check({tag, "_rsp_rdata"}, bus.rsp_rdata_o, exp_q[0]);
    end
    check({tag, "_rsp_err"}, 32'(bus.rsp_err_o), 32'(err));
  endtask

  // Complete the response handshake; returns in the following IDLE cycle.
  task automatic ack(input string tag);
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    check({tag, "_ack_idle"}, 32'(dbg_state), 32'(ST_IDLE));
    check({tag, "_ack_valid_low"}, 32'(bus.rsp_valid_o), 32'd0);
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst             = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = 5'd0;
    bus.req_wdata_i = 32'd0;
    bus.rsp_ready_i = 1'b0;
    core_we_i       = 1'b0;
    core_waddr_i    = 5'd0;
    rf_rdata_i      = 32'hBAD0_BAD0;

    // Reset state.
    repeat (2) tick();
    check("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("rst_halt", 32'(halt_req_o), 32'd0);
    check("rst_rf_we", 32'(rf_we_o), 32'd0);
    check("rst_rf_addr", 32'(rf_addr_o), 32'd0);
    check("rst_rf_wdata", rf_wdata_o, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata_o, 32'd0);
    rst = 1'b1;
    tick();

    // Unblocked write x5: write pulse in cycle 1 only, response in cycle 2.
    exp_q.push_back(32'd0);
    send("wr5", 1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    check("wr5_c1_rf_we", 32'(rf_we_o), 32'd1);
    check("wr5_c1_rf_addr", 32'(rf_addr_o), 32'd5);
    check("wr5_c1_rf_wdata", rf_wdata_o, 32'hDEAD_BEEF);
    check("wr5_c1_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("wr5_c1_req_ready", 32'(bus.req_ready_o), 32'd0);
    tick();
    check("wr5_c2_rf_we", 32'(rf_we_o), 32'd0);
    check_rsp("wr5", 1'b0);
    ack("wr5");

    // Read x7 blocked for 3 cycles by a core writeback to x7.
    core_we_i    = 1'b1;
    core_waddr_i = 5'd7;
    exp_q.push_back(32'h1234_5678);
    send("rd7", 1'b0, 5'd7, 32'd0);
    for (int c = 1; c <= 3; c++) begin
      #1;
      check("rd7_blocked_state", 32'(dbg_state), 32'(ST_ISSUE));
      check("rd7_blocked_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
      tick();
    end
    core_we_i  = 1'b0;
    rf_rdata_i = 32'h1234_5678;
    #1;
    check("rd7_c4_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    tick();
    check_rsp("rd7", 1'b0);
    ack("rd7");
    check("rd7_rdata_kept", bus.rsp_rdata_o, 32'h1234_5678);

    // Write to x0: discarded, error response with zero data.
    exp_q.push_back(32'd0);
    send("wr0", 1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    check("wr0_c1_rf_we", 32'(rf_we_o), 32'd0);
    tick();
    check("wr0_c2_rf_we", 32'(rf_we_o), 32'd0);
    check_rsp("wr0", 1'b1);
    ack("wr0");
    check("wr0_err_kept", 32'(bus.rsp_err_o), 32'd1);

    // Read x0 while the core writes back: not blocked, returns 0.
    core_we_i    = 1'b1;
    core_waddr_i = 5'd0;
    rf_rdata_i   = 32'hFFFF_FFFF;
    exp_q.push_back(32'd0);
    send("rd0", 1'b0, 5'd0, 32'd0);
    tick();
    check_rsp("rd0", 1'b0);
    ack("rd0");
    core_we_i = 1'b0;

    // Starved write: halt rises 9 cycles after entering ISSUE.
    core_we_i    = 1'b1;
    core_waddr_i = 5'd3;
    exp_q.push_back(32'd0);
    send("wr3", 1'b1, 5'd3, 32'h0000_A5A5);
    for (int c = 1; c <= 9; c++) begin
      #1;
      check("wr3_halt_low", 32'(halt_req_o), 32'd0);
      check("wr3_rf_we_low", 32'(rf_we_o), 32'd0);
      tick();
    end
    check("wr3_c10_halt", 32'(halt_req_o), 32'd1);
    check("wr3_c10_state", 32'(dbg_state), 32'(ST_ISSUE));
    check("wr3_c10_starve", 32'(dbg_starve_cnt), 32'd8);
    tick();
    core_we_i = 1'b0;
    #1;
    check("wr3_c11_rf_we", 32'(rf_we_o), 32'd1);
    check("wr3_c11_halt", 32'(halt_req_o), 32'd1);
    tick();
    check_rsp("wr3", 1'b0);
    check("wr3_c12_halt", 32'(halt_req_o), 32'd1);
    ack("wr3");
    check("wr3_halt_cleared", 32'(halt_req_o), 32'd0);

    // Response back-pressure with a new command waiting.
    rf_rdata_i = 32'hCAFE_F00D;
    exp_q.push_back(32'hCAFE_F00D);
    send("rd9", 1'b0, 5'd9, 32'd0);
    tick();
    bus.req_valid_i = 1'b1;
    bus.req_we_i    = 1'b1;
    bus.req_addr_i  = 5'd4;
    bus.req_wdata_i = 32'h0000_0011;
    for (int k = 0; k < 5; k++) begin
      rf_rdata_i = 32'(k);
      #1;
      check_rsp("rd9_hold", 1'b0);
      check("rd9_hold_req_ready", 32'(bus.req_ready_o), 32'd0);
      check("rd9_hold_rf_addr", 32'(rf_addr_o), 32'd9);
      tick();
    end
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    check("wr4_accept_ready", 32'(bus.req_ready_o), 32'd1);
    check("wr4_rsp_valid_low", 32'(bus.rsp_valid_o), 32'd0);
    exp_q.push_back(32'd0);
    tick();
    bus.req_valid_i = 1'b0;
    #1;
    check("wr4_c1_rf_we", 32'(rf_we_o), 32'd1);
    check("wr4_c1_rf_addr", 32'(rf_addr_o), 32'd4);
    check("wr4_c1_rf_wdata", rf_wdata_o, 32'h0000_0011);
    tick();
    check_rsp("wr4", 1'b0);
    ack("wr4");

    // Reset during the ISSUE cycle of an unblocked write.
    send("abort", 1'b1, 5'd6, 32'h0000_0077);
    rst = 1'b0;
    #1;
    check("abort_rf_we", 32'(rf_we_o), 32'd0);
    tick();
    rst = 1'b1;
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    check("abort_req_ready", 32'(bus.req_ready_o), 32'd1);
    check("abort_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("abort_rf_addr", 32'(rf_addr_o), 32'd0);
    tick();
    check("abort_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
    check("abort_no_rf_we", 32'(rf_we_o), 32'd0);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_dbg_seq.md
REG_DBG_SEQ -- requirements
Module: reg_dbg_seq

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning the number of consecutive blocked ISSUE cycles before halt is requested (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port req_valid_i, input, 1, meaning the debug host presents a command.
REQ-005 SHALL have port req_ready_o, output, 1, meaning the command is accepted this cycle.
REQ-006 SHALL have port req_we_i, input, 1, selecting write (1) or read (0).
REQ-007 SHALL have port req_addr_i, input, 5, the target register index.
REQ-008 SHALL have port req_wdata_i, input, 32, the write data.
REQ-009 SHALL have port rsp_valid_o, output, 1, meaning a response is presented.
REQ-010 SHALL have port rsp_ready_i, input, 1, meaning the host consumes the response.
REQ-011 SHALL have port rsp_rdata_o, output, 32, the read data (0 for writes).
REQ-012 SHALL have port rsp_err_o, output, 1, meaning the write targeted x0 and was discarded.
REQ-013 SHALL have port core_we_i, input, 1, the core writeback enable of the register file.
REQ-014 SHALL have port core_waddr_i, input, 5, the core writeback address.
REQ-015 SHALL have port halt_req_o, output, 1, the request to the core to stall writeback.
REQ-016 SHALL have port rf_we_o, output, 1, the register-file debug-port write enable.
REQ-017 SHALL have port rf_addr_o, output, 5, the register-file debug-port address.
REQ-018 SHALL have port rf_wdata_o, output, 32, the register-file debug-port write data.
REQ-019 SHALL have port rf_rdata_i, input, 32, the register-file debug-port read data (combinational from rf_addr_o).

Function
REQ-020 SHALL implement states IDLE, ISSUE and RESP, and SHALL hold at most one outstanding command.
REQ-021 SHALL drive req_ready_o = 1 only in IDLE; on req_valid_i & req_ready_o it SHALL register we/addr/wdata, clear the starve counter and enter ISSUE next cycle.
REQ-022 SHALL drive rf_addr_o and rf_wdata_o from the captured registers at all times.
REQ-023 SHALL define blocked = core_we_i & (core_waddr_i != 0) for writes, and core_we_i & (core_waddr_i == captured addr) & (addr != 0) for reads.
REQ-024 In ISSUE with a write to a non-zero address and not blocked, SHALL assert rf_we_o combinationally for exactly that one cycle and enter RESP with rsp_err 0.
REQ-025 In ISSUE with a write to x0, SHALL leave rf_we_o low, enter RESP next cycle and set rsp_err 1.
REQ-026 In ISSUE with a read that is not blocked, SHALL capture rf_rdata_i into rsp_rdata and enter RESP; a read of x0 SHALL return 0 without blocking.
REQ-027 In ISSUE while blocked, SHALL stay in ISSUE and increment the starve counter, saturating at STARVE_LIMIT.
REQ-028 SHALL set halt_req_o (registered) in the cycle after the counter reaches STARVE_LIMIT, and SHALL hold it until the RESP handshake completes.
REQ-029 In RESP, SHALL hold rsp_valid_o = 1 with stable rsp_rdata_o/rsp_err_o until rsp_ready_i; on handshake it SHALL return to IDLE and clear halt_req_o the next cycle.
REQ-030 SHALL keep rsp_rdata_o and rsp_err_o at their last values outside RESP; write responses SHALL carry rsp_rdata_o = 0.
REQ-031 Minimum latency SHALL be accept (cycle 0) -> ISSUE (cycle 1) -> rsp_valid_o (cycle 2).
REQ-032 SHALL ignore req_valid_i outside IDLE with no side effects.

Reset
REQ-033 While rst = 0 at a rising edge, SHALL load state IDLE, starve counter 0, captured addr/wdata/we 0, rsp data/err 0 and halt_req_o 0.
REQ-034 SHALL force rf_we_o = 0 combinationally whenever rst = 0, so a reset asserted mid-ISSUE never issues a write; the aborted command produces no response.
REQ-035 After reset, outputs SHALL be req_ready_o = 1, rsp_valid_o = 0, halt_req_o = 0, rf_we_o = 0, rf_addr_o = 0, rf_wdata_o = 0.

Verification
REQ-036 Write x5 = 0xDEADBEEF with core_we_i = 0 -> rf_we_o high in cycle 1 only, rf_addr_o = 5; rsp_valid_o in cycle 2 with err 0.
REQ-037 Read x7 while core_we_i = 1 and core_waddr_i = 7 for 3 cycles, rf_rdata_i = 0x12345678 afterwards -> response rdata 0x12345678 exactly one cycle after the blocking ends.
REQ-038 Write while core_we_i = 1 and core_waddr_i = 3 continuously, STARVE_LIMIT = 8 -> halt_req_o rises 9 cycles after entering ISSUE; dropping core_we_i completes the write; halt_req_o falls after rsp_ready_i.
REQ-039 Write x0 = 0xFFFFFFFF -> rf_we_o is never high; response has err 1 and rdata 0.
REQ-040 Hold rsp_ready_i = 0 for 5 cycles with a new req_valid_i present -> rsp held stable and req_ready_o = 0 throughout; the new command is accepted the cycle after the handshake.
REQ-041 Drive rst = 0 in the ISSUE cycle of an unblocked write -> rf_we_o stays 0, and the next cycle has IDLE, req_ready_o = 1 and no response.
